// File: rtl/alu_operand_pipe_if.sv
// Handshake bundle for the registered ALU operand-B selector.
// master drives words in and accepts results; slave is the pipe.
interface alu_operand_pipe_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 5,
  parameter int SEL_W   = 3
) ();
  logic                     in_valid;
  logic                     in_ready;
  logic [SEL_W-1:0]         sel;
  logic [NUM_SRC*WIDTH-1:0] src_bus;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         result;
  logic [SEL_W-1:0]         out_sel;
  logic                     sel_err;
  logic [1:0]               occupancy;

  modport master (
    output in_valid, sel, src_bus, out_ready,
    input  in_ready, out_valid, result,
    input  out_sel, sel_err, occupancy
  );

  modport slave (
    input  in_valid, sel, src_bus, out_ready,
    output in_ready, out_valid, result,
    output out_sel, sel_err, occupancy
  );
endinterface

// File: rtl/alu_operand_pipe.sv
// ALU operand-B slot selector with per-slot transforms,
// registered behind a 2-entry valid/ready skid buffer.
module alu_operand_pipe #(
  parameter int WIDTH      = 32,
  parameter int NUM_SRC    = 5,
  parameter int SEL_W      = 3,
  parameter int CONST_SLOT = 1,
  parameter int CONST_VAL  = 4,
  parameter int SHIFT_SLOT = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  alu_operand_pipe_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
    logic             err;
  } word_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic             in_ready_q;
  logic             out_valid_q;
  word_t            main_q;
  word_t            main_d;
  word_t            skid_q;
  word_t            skid_d;
  word_t            sel_word;
  logic [WIDTH-1:0] slot;
  logic             push;
  logic             pop;

  assign push = bus.in_valid & in_ready_q;
  assign pop  = out_valid_q & bus.out_ready;

  // Pick the addressed slot and apply its transform.
  always_comb begin
    slot     = '0;
    sel_word = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        slot = bus.src_bus[k*WIDTH +: WIDTH];
      end
    end
    sel_word.sel = bus.sel;
    if (32'(bus.sel) >= 32'(NUM_SRC)) begin
      sel_word.err = 1'b1;
    end else if (bus.sel == SEL_W'(CONST_SLOT)) begin
      sel_word.data = WIDTH'(CONST_VAL);
    end else if (bus.sel == SEL_W'(SHIFT_SLOT)) begin
      sel_word.data = {slot[WIDTH-3:0], 2'b00};
    end else begin
      sel_word.data = slot;
    end
  end

  // Occupancy FSM and main/skid load steering.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      S_EMPTY: begin
        if (push) begin
          state_d = S_ONE;
          main_d  = sel_word;
        end
      end
      S_ONE: begin
        if (push && !pop) begin
          state_d = S_FULL;
          skid_d  = sel_word;
        end else if (push && pop) begin
          main_d = sel_word;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (pop) begin
          state_d = S_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // State and handshake flags, registered from next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != S_FULL);
      out_valid_q <= (state_d != S_EMPTY);
    end
  end

  // Word storage; held when not loaded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = main_q.data;
  assign bus.out_sel   = main_q.sel;
  assign bus.sel_err   = main_q.err;
  assign bus.occupancy = state_q;

endmodule

// File: tb/tb_alu_operand_pipe.sv
// Scoreboard bench for alu_operand_pipe: random and
// directed words checked against a slot-rule model.
module tb_alu_operand_pipe;

  localparam int W  = 32;
  localparam int N  = 5;
  localparam int SW = 3;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [SW-1:0] sel;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_operand_pipe_if #(
    .WIDTH(W), .NUM_SRC(N), .SEL_W(SW)
  ) ifc ();

  alu_operand_pipe #(
    .WIDTH(W), .NUM_SRC(N), .SEL_W(SW),
    .CONST_SLOT(1), .CONST_VAL(4), .SHIFT_SLOT(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(ifc)
  );

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic exp_t model(
    input logic [SW-1:0] s,
    input logic [N*W-1:0] b
  );
    exp_t e;
    logic [W-1:0] slot;
    int idx;
    idx = int'(s);
    e = '0;
    e.sel = s;
    if (idx >= N) begin
      e.err = 1'b1;
      return e;
    end
    slot = W'(b >> (W * idx));
    if (idx == 1) e.data = 32'd4;
    else if (idx == 3) e.data = slot * 32'd4;
    else e.data = slot;
    return e;
  endfunction

  function automatic logic [N*W-1:0] rnd_bus();
    return {$urandom, $urandom, $urandom,
            $urandom, $urandom};
  endfunction

  task automatic chk(
    input string nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic drive(
    input logic v,
    input logic [SW-1:0] s,
    input logic [N*W-1:0] b
  );
    ifc.in_valid = v;
    ifc.sel      = s;
    ifc.src_bus  = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare on pop, record expectation on push.
  logic hold_v = 1'b0;
  exp_t hold_w;
  always @(negedge clk) begin
    exp_t e;
    exp_t cur;
    if (!reset_n) begin
      hold_v = 1'b0;
    end else begin
      cur = {ifc.result, ifc.out_sel, ifc.sel_err};
      if (hold_v) chk("stall_stable", cur, hold_w);
      chk("occ_le2", ifc.occupancy <= 2'd2, 1);
      if (ifc.out_valid && ifc.out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk("sb_result", ifc.result, e.data);
          chk("sb_out_sel", ifc.out_sel, e.sel);
          chk("sb_sel_err", ifc.sel_err, e.err);
        end
      end
      if (ifc.in_valid && ifc.in_ready)
        q.push_back(model(ifc.sel, ifc.src_bus));
      hold_v = ifc.out_valid && !ifc.out_ready;
      hold_w = cur;
    end
  end

  initial begin
    logic [N*W-1:0] b;
    int k;
    drive(1'b0, '0, '0);
    ifc.out_ready = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // Stall: A then B with out_ready low.
    b = rnd_bus();
    b[31:0] = 32'h1111_2222;
    drive(1'b1, 3'd0, b);
    tick();
    b[31:0] = 32'h3333_4444;
    drive(1'b1, 3'd0, b);
    tick();
    drive(1'b0, 3'd0, b);
    chk("stall_occ", ifc.occupancy, 2);
    chk("stall_in_ready", ifc.in_ready, 0);
    chk("stall_result_a", ifc.result, 32'h1111_2222);
    tick();
    chk("stall_hold_a", ifc.result, 32'h1111_2222);
    ifc.out_ready = 1'b1;
    tick();
    chk("pop_result_b", ifc.result, 32'h3333_4444);
    chk("pop_occ", ifc.occupancy, 1);
    chk("pop_in_ready", ifc.in_ready, 1);
    tick();
    chk("drain_valid", ifc.out_valid, 0);

    // Reset mid-FULL.
    ifc.out_ready = 1'b0;
    drive(1'b1, 3'd2, rnd_bus());
    tick();
    drive(1'b1, 3'd4, rnd_bus());
    tick();
    drive(1'b0, 3'd0, '0);
    chk("pre_rst_occ", ifc.occupancy, 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_in_ready", ifc.in_ready, 1);
    chk("rst_occ", ifc.occupancy, 0);
    chk("rst_result", ifc.result, 0);
    chk("rst_out_sel", ifc.out_sel, 0);
    chk("rst_sel_err", ifc.sel_err, 0);
    q.delete();
    tick();
    reset_n = 1'b1;
    ifc.out_ready = 1'b1;

    // Selection rules, one word per cycle.
    b = rnd_bus();
    b[31:0] = 32'hDEAD_BEEF;
    b[96 +: 32] = 32'hC000_0001;
    drive(1'b1, 3'd0, b);
    tick();
    chk("first_push_valid", ifc.out_valid, 1);
    chk("sel0_result", ifc.result, 32'hDEAD_BEEF);
    chk("sel0_err", ifc.sel_err, 0);
    drive(1'b1, 3'd1, b);
    tick();
    chk("sel1_const", ifc.result, 32'h4);
    drive(1'b1, 3'd3, b);
    tick();
    chk("sel3_shift", ifc.result, 32'h4);
    drive(1'b1, 3'd7, b);
    tick();
    chk("sel7_result", ifc.result, 0);
    chk("sel7_err", ifc.sel_err, 1);
    chk("sel7_out_sel", ifc.out_sel, 7);
    drive(1'b0, 3'd0, b);
    tick();
    chk("sel_drain", ifc.out_valid, 0);

    // Streaming: no bubbles, 1-cycle latency.
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, SW'($urandom_range(0, 7)), rnd_bus());
      tick();
      chk("stream_valid", ifc.out_valid, 1);
      chk("stream_ready", ifc.in_ready, 1);
    end
    drive(1'b0, 3'd0, '0);
    tick();
    chk("stream_drained", q.size(), 0);

    // Random valid/ready backpressure.
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)),
            SW'($urandom_range(0, 7)), rnd_bus());
      ifc.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drive(1'b0, 3'd0, '0);
    ifc.out_ready = 1'b1;
    k = 0;
    while (q.size() != 0 && k < 10) begin
      tick();
      k++;
    end
    tick();
    chk("final_queue_empty", q.size(), 0);
    chk("final_out_valid", ifc.out_valid, 0);
    chk("final_occ", ifc.occupancy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
